// File: rtl/memory_responder_if.sv
// memory_responder_if: processor-to-memory request/response bundle.
//   master (processor): drives MEM_read, MEM_write, Address, DataOut; receives DataIn, MFC, MEM_error, Busy
//   slave  (memory)   : the mirror image of master
interface memory_responder_if;
    logic        MEM_read;
    logic        MEM_write;
    logic [31:0] Address;
    logic [31:0] DataOut;
    logic [31:0] DataIn;
    logic        MFC;
    logic        MEM_error;
    logic        Busy;
    modport master (output MEM_read, MEM_write, Address, DataOut,
                    input  DataIn, MFC, MEM_error, Busy);
    modport slave  (input  MEM_read, MEM_write, Address, DataOut,
                    output DataIn, MFC, MEM_error, Busy);
endinterface

// File: rtl/memory_responder.sv
// memory_responder: wait-state word memory answering processor read/write requests with an MFC pulse.
//   clk, reset : clock and synchronous active-high reset
//   bus.slave  : MEM_read/MEM_write/Address/DataOut in; DataIn/MFC/MEM_error/Busy out
module memory_responder #(
    parameter int ADDR_WORDS_LOG2 = 8,
    parameter int WAIT_CYCLES     = 2
) (
    input logic               clk,
    input logic               reset,
    memory_responder_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE, S_RELEASE} state_t;
    state_t                       state_q, state_d;
    logic [3:0]                   cnt_q, cnt_d;
    logic [ADDR_WORDS_LOG2-1:0]   idx_q, idx_d;
    logic [31:0]                  wdata_q, wdata_d;
    logic [31:0]                  rdata_q, rdata_d;
    logic                         we_q, we_d;
    logic                         err_q, err_d;
    logic                         mem_we;
    logic [31:0]                  mem [2**ADDR_WORDS_LOG2];
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        we_d    = we_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE:
                if (bus.MEM_read || bus.MEM_write) begin
                    idx_d   = bus.Address[ADDR_WORDS_LOG2+1:2];
                    wdata_d = bus.DataOut;
                    we_d    = bus.MEM_write;
                    // Error is fully decided at acceptance: conflicting request, misalignment, or address past the array.
                    err_d   = (bus.MEM_read && bus.MEM_write) || (bus.Address[1:0] != 2'b00) ||
                              ((bus.Address >> (ADDR_WORDS_LOG2 + 2)) != 32'd0);
                    cnt_d   = 4'(WAIT_CYCLES);
                    state_d = S_WAIT;
                end
            S_WAIT:
                if (cnt_q == 4'd0) begin
                    rdata_d = (!we_q && !err_q) ? mem[idx_q] : rdata_q;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            S_DONE:    state_d = S_RELEASE;
            S_RELEASE: state_d = (bus.MEM_read || bus.MEM_write) ? S_RELEASE : S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end
    assign mem_we = (state_q == S_WAIT) && (cnt_q == 4'd0) && we_q && !err_q;
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            we_q    <= we_d;
            err_q   <= err_d;
        end
    end
    // The array keeps its contents across reset; reset only suppresses a write that would land on the same edge.
    always_ff @(posedge clk) begin
        if (mem_we && !reset)
            mem[idx_q] <= wdata_q;
    end
    assign bus.MFC       = (state_q == S_DONE);
    assign bus.MEM_error = (state_q == S_DONE) && err_q;
    assign bus.Busy      = (state_q != S_IDLE);
    assign bus.DataIn    = rdata_q;
endmodule
